// File: rtl/snn_mem_arbiter_rr.sv
// snn_mem_arbiter_rr
// N-client round-robin arbiter for the dual-port feature-map BRAM of the SNN
// conv/pool pipeline. Port A is read-only and port B is write-only. The two
// ports are arbitrated independently, so one read and one write can be granted
// in the same cycle.
// Reads travel through a tagged pipeline of READ_LATENCY stages. This returns
// the data to the client that issued the read. Granted writes to the same
// address are forwarded into reads that are still in flight.
// Out-of-range coordinates are still granted, but they never reach the BRAM.
// Optional feature: define SNN_ARB_STATS_EN to build the conflict_cnt
// contention counter. Without it, conflict_cnt is tied to 0.
module snn_mem_arbiter_rr #(
  parameter int N_CLIENTS        = 2,
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8,
  parameter int IMG_WIDTH        = 32,
  parameter int IMG_HEIGHT       = 32,
  parameter int READ_LATENCY     = 1,
  parameter int DATA_W           = CHANNELS * BITS_PER_CHANNEL,
  parameter int ADDR_W           = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [N_CLIENTS-1:0]             rd_req,
  input  logic [N_CLIENTS*COORD_BITS-1:0]  rd_x,
  input  logic [N_CLIENTS*COORD_BITS-1:0]  rd_y,
  output logic [N_CLIENTS-1:0]             rd_gnt,
  output logic [N_CLIENTS-1:0]             rd_valid,
  output logic [DATA_W-1:0]                rd_data,
  input  logic [N_CLIENTS-1:0]             wr_req,
  input  logic [N_CLIENTS*COORD_BITS-1:0]  wr_x,
  input  logic [N_CLIENTS*COORD_BITS-1:0]  wr_y,
  input  logic [N_CLIENTS*DATA_W-1:0]      wr_data,
  output logic [N_CLIENTS-1:0]             wr_gnt,
  output logic [ADDR_W-1:0]                bram_addr_a,
  output logic                             bram_en_a,
  input  logic [DATA_W-1:0]                bram_dout_a,
  output logic [ADDR_W-1:0]                bram_addr_b,
  output logic                             bram_en_b,
  output logic                             bram_we_b,
  output logic [DATA_W-1:0]                bram_din_b,
  output logic                             oob_err,
  output logic                             busy,
  output logic [15:0]                      conflict_cnt
);

  localparam int TAG_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int LAST  = READ_LATENCY - 1;

  // Returns {found, index} of the first requester at or after ptr, with wrap-around.
  function automatic logic [TAG_W:0] rr_pick(input logic [N_CLIENTS-1:0] req,
                                             input logic [TAG_W-1:0] ptr);
    logic [TAG_W:0] res;
    int idx;
    res = '0;
    // Scan from the farthest offset down so that the nearest requester wins.
    for (int off = N_CLIENTS - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N_CLIENTS;
      if (req[idx]) res = {1'b1, TAG_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [TAG_W-1:0] ptr_after(input logic [TAG_W-1:0] k);
    return (int'(k) == N_CLIENTS - 1) ? '0 : k + 1'b1;
  endfunction

  function automatic logic coord_ok(input logic [COORD_BITS-1:0] x,
                                    input logic [COORD_BITS-1:0] y);
    return (int'(x) < IMG_WIDTH) && (int'(y) < IMG_HEIGHT);
  endfunction

  function automatic logic [ADDR_W-1:0] map_addr(input logic [COORD_BITS-1:0] x,
                                                 input logic [COORD_BITS-1:0] y);
    return ADDR_W'(y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x);
  endfunction

  logic [TAG_W-1:0]      rd_ptr, wr_ptr;
  logic [TAG_W:0]        rd_pick, wr_pick;
  logic                  rd_fire, wr_fire;
  logic [TAG_W-1:0]      rd_win, wr_win;
  logic [COORD_BITS-1:0] rd_cx, rd_cy, wr_cx, wr_cy;
  logic                  rd_ok, wr_ok;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic [DATA_W-1:0]     wr_word;
  logic                  wr_store;

  // Read pipeline: stage 0 is loaded in the grant cycle, and stage LAST returns data.
  logic [READ_LATENCY-1:0] st_valid, st_oob, st_hit;
  logic [TAG_W-1:0]        st_tag [READ_LATENCY];
  logic [ADDR_W-1:0]       st_addr [READ_LATENCY];
  logic [DATA_W-1:0]       st_fwd [READ_LATENCY];
  logic                    new_hit;
  logic [READ_LATENCY-1:0] st_wr_hit;
  logic                    any_valid;

  // Pick the winner on each port and pull out its coordinate, address and data.
  always_comb begin
    rd_pick = rr_pick(rd_req, rd_ptr);
    wr_pick = rr_pick(wr_req, wr_ptr);
    rd_fire = enable & rd_pick[TAG_W];
    wr_fire = enable & wr_pick[TAG_W];
    rd_win  = rd_pick[TAG_W-1:0];
    wr_win  = wr_pick[TAG_W-1:0];
    rd_cx   = rd_x[int'(rd_win)*COORD_BITS +: COORD_BITS];
    rd_cy   = rd_y[int'(rd_win)*COORD_BITS +: COORD_BITS];
    wr_cx   = wr_x[int'(wr_win)*COORD_BITS +: COORD_BITS];
    wr_cy   = wr_y[int'(wr_win)*COORD_BITS +: COORD_BITS];
    wr_word = wr_data[int'(wr_win)*DATA_W +: DATA_W];
    rd_ok   = coord_ok(rd_cx, rd_cy);
    wr_ok   = coord_ok(wr_cx, wr_cy);
    rd_addr = map_addr(rd_cx, rd_cy);
    wr_addr = map_addr(wr_cx, wr_cy);
    rd_gnt  = '0;
    wr_gnt  = '0;
    if (rd_fire) rd_gnt[rd_win] = 1'b1;
    if (wr_fire) wr_gnt[wr_win] = 1'b1;
  end

  // Drive the BRAM ports. Out-of-range grants leave the enables low.
  always_comb begin
    wr_store    = wr_fire & wr_ok;
    bram_en_a   = rd_fire & rd_ok;
    bram_addr_a = bram_en_a ? rd_addr : '0;
    bram_en_b   = wr_store;
    bram_we_b   = wr_store;
    bram_addr_b = wr_store ? wr_addr : '0;
    bram_din_b  = wr_store ? wr_word : '0;
  end

  // Detect same-address writes against the new read and against every in-flight stage.
  always_comb begin
    new_hit   = wr_store & rd_fire & rd_ok & (wr_addr == rd_addr);
    st_wr_hit = '0;
    any_valid = 1'b0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      st_wr_hit[k] = wr_store & st_valid[k] & ~st_oob[k] & (wr_addr == st_addr[k]);
      any_valid    = any_valid | st_valid[k];
    end
  end

  // Advance the read pipeline. A write seen while an entry moves forward overrides older forwarded data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_oob   <= '0;
      st_hit   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        st_tag[k]  <= '0;
        st_addr[k] <= '0;
        st_fwd[k]  <= '0;
      end
    end else begin
      st_valid[0] <= rd_fire;
      st_tag[0]   <= rd_win;
      st_addr[0]  <= rd_addr;
      st_oob[0]   <= ~rd_ok;
      st_hit[0]   <= new_hit;
      st_fwd[0]   <= wr_word;
      for (int k = 1; k < READ_LATENCY; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_tag[k]   <= st_tag[k-1];
        st_addr[k]  <= st_addr[k-1];
        st_oob[k]   <= st_oob[k-1];
        st_hit[k]   <= st_hit[k-1] | st_wr_hit[k-1];
        st_fwd[k]   <= st_wr_hit[k-1] ? wr_word : st_fwd[k-1];
      end
    end
  end

  // Return the oldest entry to its client: zero if out of range, else forwarded data, else BRAM data.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (st_valid[LAST]) begin
      rd_valid[st_tag[LAST]] = 1'b1;
      if (st_oob[LAST])      rd_data = '0;
      else if (st_hit[LAST]) rd_data = st_fwd[LAST];
      else                   rd_data = bram_dout_a;
    end
  end

  // Round-robin pointers move to the client after the winner, and hold when there is no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rd_fire) rd_ptr <= ptr_after(rd_win);
      if (wr_fire) wr_ptr <= ptr_after(wr_win);
    end
  end

  // One-cycle pulse after any grant whose coordinate was off the grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob_err <= 1'b0;
    else        oob_err <= (rd_fire & ~rd_ok) | (wr_fire & ~wr_ok);
  end

  assign busy = (|rd_req) | (|wr_req) | any_valid;

`ifdef SNN_ARB_STATS_EN
  logic multi_rd, multi_wr;
  // req & (req - 1) is nonzero exactly when more than one bit is set.
  assign multi_rd = |(rd_req & (rd_req - 1'b1));
  assign multi_wr = |(wr_req & (wr_req - 1'b1));

  // Saturating count of the cycles in which more than one client contends on either port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (enable && (multi_rd || multi_wr) && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_snn_mem_arbiter_rr.sv
// Testbench for snn_mem_arbiter_rr (3 clients, READ_LATENCY=2, 32x32 grid).
// Directed cases cover:
//   - round-robin order,
//   - address mapping,
//   - write forwarding,
//   - out-of-range reads,
//   - enable drop,
//   - reset while a read is in flight.
// These are followed by a randomized phase. A transaction-level reference model
// predicts grants, BRAM strobes and read returns: it keeps per-client pending
// requests, the golden memory contents and a queue of outstanding reads.
module tb_snn_mem_arbiter_rr;
  localparam int N  = 3;
  localparam int CB = 8;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int L  = 2;
  localparam int W  = 32;
  localparam int H  = 32;

  logic clk, rst_n, enable;
  logic [N-1:0]    rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
  logic [N*CB-1:0] rd_x, rd_y, wr_x, wr_y;
  logic [N*DW-1:0] wr_data;
  logic [DW-1:0]   rd_data, bram_dout_a, bram_din_b;
  logic [AW-1:0]   bram_addr_a, bram_addr_b;
  logic            bram_en_a, bram_en_b, bram_we_b, oob_err, busy;
  logic [15:0]     conflict_cnt;

  snn_mem_arbiter_rr #(
    .N_CLIENTS(N), .COORD_BITS(CB), .CHANNELS(4), .BITS_PER_CHANNEL(8),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .bram_addr_a(bram_addr_a), .bram_en_a(bram_en_a), .bram_dout_a(bram_dout_a),
    .bram_addr_b(bram_addr_b), .bram_en_b(bram_en_b), .bram_we_b(bram_we_b),
    .bram_din_b(bram_din_b), .oob_err(oob_err), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed_word(input int i);
    return 32'(i) * 32'h9E3779B1 ^ 32'hC3A50F1E;
  endfunction

  // BRAM model: read-first, with a two-cycle registered read on port A.
  logic [DW-1:0] bram [1024];
  logic [DW-1:0] bram_q1, bram_q2;
  logic          init_go;
  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++) bram[i] <= seed_word(i);
    end else if (bram_en_b && bram_we_b) begin
      bram[bram_addr_b] <= bram_din_b;
    end
    if (bram_en_a) bram_q1 <= bram[bram_addr_a];
    bram_q2 <= bram_q1;
  end
  assign bram_dout_a = bram_q2;

  // Reference model state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [1024];
  bit  rd_pend [N];
  bit  wr_pend [N];
  int  rd_xv [N], rd_yv [N], wr_xv [N], wr_yv [N];
  logic [DW-1:0] wr_dv [N];
  int  rd_ptr_m, wr_ptr_m, cyc, conf_m;
  bit  oob_next_m;
  typedef struct {int due; int client; int addr; bit oob;} ret_t;
  ret_t ret_q[$];

  // Observations captured by the last cycle, used by directed checks.
  logic [N-1:0]  obs_rd_gnt, obs_rd_valid;
  logic [DW-1:0] obs_rd_data;
  logic [AW-1:0] obs_addr_a;
  logic          obs_en_a, obs_oob;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic bit ok_xy(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  // Returns the first pending client at or after ptr in ring order, or -1 if none.
  function automatic int ring_first(input bit p [N], input int ptr);
    for (int off = 0; off < N; off++)
      if (p[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  function automatic int n_pend(input bit p [N]);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(p[i]);
    return c;
  endfunction

  function automatic int rand_coord();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 45)) : int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    rd_ptr_m = 0; wr_ptr_m = 0; conf_m = 0; oob_next_m = 0;
    ret_q.delete();
    for (int i = 0; i < N; i++) begin rd_pend[i] = 0; wr_pend[i] = 0; end
  endtask

  // One cycle with reset asserted. Every output must be zero.
  task automatic reset_cycle();
    enable = 0; rd_req = '0; wr_req = '0;
    rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
    #1;
    check_val("rst_rd_gnt", 64'(rd_gnt), 64'(0));
    check_val("rst_wr_gnt", 64'(wr_gnt), 64'(0));
    check_val("rst_rd_valid", 64'(rd_valid), 64'(0));
    check_val("rst_rd_data", 64'(rd_data), 64'(0));
    check_val("rst_oob_err", 64'(oob_err), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_en_a", 64'(bram_en_a), 64'(0));
    check_val("rst_en_b", 64'(bram_en_b), 64'(0));
    check_val("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
    @(negedge clk);
  endtask

  // One normal cycle. Drive the pending requests, compare against the model, then advance the model.
  task automatic run_cycle();
    int rw, ww, ra, wa;
    logic [N-1:0] eg_r, eg_w, ev;
    logic [DW-1:0] ed;
    bit en_a_e, en_b_e, busy_e;
    rd_req = '0; wr_req = '0; rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_pend[i]) begin
        rd_req[i] = 1'b1; rd_x[i*CB +: CB] = CB'(rd_xv[i]); rd_y[i*CB +: CB] = CB'(rd_yv[i]);
      end
      if (wr_pend[i]) begin
        wr_req[i] = 1'b1; wr_x[i*CB +: CB] = CB'(wr_xv[i]); wr_y[i*CB +: CB] = CB'(wr_yv[i]);
        wr_data[i*DW +: DW] = wr_dv[i];
      end
    end
    #1;
    rw = enable ? ring_first(rd_pend, rd_ptr_m) : -1;
    ww = enable ? ring_first(wr_pend, wr_ptr_m) : -1;
    eg_r = '0; eg_w = '0;
    if (rw >= 0) eg_r[rw] = 1'b1;
    if (ww >= 0) eg_w[ww] = 1'b1;
    check_val("rd_gnt", 64'(rd_gnt), 64'(eg_r));
    check_val("wr_gnt", 64'(wr_gnt), 64'(eg_w));
    en_a_e = (rw >= 0) && ok_xy(rd_xv[rw], rd_yv[rw]);
    en_b_e = (ww >= 0) && ok_xy(wr_xv[ww], wr_yv[ww]);
    ra = (rw >= 0) ? rd_yv[rw] * W + rd_xv[rw] : 0;
    wa = (ww >= 0) ? wr_yv[ww] * W + wr_xv[ww] : 0;
    check_val("bram_en_a", 64'(bram_en_a), 64'(en_a_e));
    if (en_a_e) check_val("bram_addr_a", 64'(bram_addr_a), 64'(ra));
    check_val("bram_en_b", 64'(bram_en_b), 64'(en_b_e));
    check_val("bram_we_b", 64'(bram_we_b), 64'(en_b_e));
    if (en_b_e) begin
      check_val("bram_addr_b", 64'(bram_addr_b), 64'(wa));
      check_val("bram_din_b", 64'(bram_din_b), 64'(wr_dv[ww]));
    end
    ev = '0; ed = '0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      ev[ret_q[0].client] = 1'b1;
      ed = ret_q[0].oob ? '0 : ref_mem[ret_q[0].addr];
    end
    check_val("rd_valid", 64'(rd_valid), 64'(ev));
    if (ev != 0) check_val("rd_data", 64'(rd_data), 64'(ed));
    check_val("oob_err", 64'(oob_err), 64'(oob_next_m));
    busy_e = (n_pend(rd_pend) > 0) || (n_pend(wr_pend) > 0) || (ret_q.size() > 0);
    check_val("busy", 64'(busy), 64'(busy_e));
    check_val("conflict_cnt", 64'(conflict_cnt), 64'(conf_m));
    obs_rd_gnt = rd_gnt; obs_rd_valid = rd_valid; obs_rd_data = rd_data;
    obs_addr_a = bram_addr_a; obs_en_a = bram_en_a; obs_oob = oob_err;
`ifdef SNN_ARB_STATS_EN
    if (rd_gnt != 0 || wr_gnt != 0)
      $display("GNT t=%0t rd_gnt=%b wr_gnt=%b conflict_cnt=%0d", $time, rd_gnt, wr_gnt, conflict_cnt);
    if (enable && (n_pend(rd_pend) > 1 || n_pend(wr_pend) > 1) && conf_m < 65535) conf_m++;
`endif
    if (ev != 0) begin
      $display("RD client=%0d addr=%0d oob=%0d data=%h", ret_q[0].client, ret_q[0].addr,
               ret_q[0].oob, rd_data);
      void'(ret_q.pop_front());
    end
    oob_next_m = (rw >= 0 && !en_a_e) || (ww >= 0 && !en_b_e);
    if (rw >= 0) begin
      ret_q.push_back('{cyc + L, rw, ra, !en_a_e});
      rd_ptr_m = (rw + 1) % N;
      rd_pend[rw] = 0;
    end
    if (ww >= 0) begin
      if (en_b_e) ref_mem[wa] = wr_dv[ww];
      $display("WR client=%0d x=%0d y=%0d data=%h", ww, wr_xv[ww], wr_yv[ww], wr_dv[ww]);
      wr_ptr_m = (ww + 1) % N;
      wr_pend[ww] = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    enable = 1;
    while ((n_pend(rd_pend) > 0 || n_pend(wr_pend) > 0 || ret_q.size() > 0) && guard < 100) begin
      run_cycle();
      guard++;
    end
    check_val("drain_timeout", 64'(guard < 100), 64'(1));
  endtask

  task automatic gen_requests();
    for (int i = 0; i < N; i++) begin
      if (!rd_pend[i] && $urandom_range(0, 99) < 45) begin
        rd_pend[i] = 1; rd_xv[i] = rand_coord(); rd_yv[i] = rand_coord();
      end
      if (!wr_pend[i] && $urandom_range(0, 99) < 40) begin
        wr_pend[i] = 1; wr_xv[i] = rand_coord(); wr_yv[i] = rand_coord(); wr_dv[i] = $urandom;
      end
    end
    enable = ($urandom_range(0, 15) != 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
    model_reset();
    cyc = 0;
    rst_n = 0; init_go = 1; enable = 0;
    rd_req = '0; wr_req = '0; rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
    @(negedge clk);
    init_go = 0;
    reset_cycle();
    reset_cycle();
    rst_n = 1;

    // Round robin: all three clients keep requesting for six cycles.
    enable = 1;
    for (int i = 0; i < N; i++) begin rd_pend[i] = 1; rd_xv[i] = i; rd_yv[i] = 0; end
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      check_val("rr_seq", 64'(obs_rd_gnt), 64'(1 << (k % 3)));
      for (int i = 0; i < N; i++) rd_pend[i] = 1;
    end
    drain();

    // Address mapping: client 1 reads (3,2), which maps to address 67.
    rd_pend[1] = 1; rd_xv[1] = 3; rd_yv[1] = 2;
    run_cycle();
    check_val("addr_67", 64'(obs_addr_a), 64'(67));
    check_val("addr_67_en", 64'(obs_en_a), 64'(1));
    run_cycle();
    run_cycle();
    check_val("addr_67_valid", 64'(obs_rd_valid), 64'(3'b010));
    drain();

    // Forwarding: client 1 reads (5,5), and client 0 writes it one cycle later.
    rd_pend[1] = 1; rd_xv[1] = 5; rd_yv[1] = 5;
    run_cycle();
    wr_pend[0] = 1; wr_xv[0] = 5; wr_yv[0] = 5; wr_dv[0] = 32'hA5A5A5A5;
    run_cycle();
    run_cycle();
    check_val("fwd_valid", 64'(obs_rd_valid), 64'(3'b010));
    check_val("fwd_data", 64'(obs_rd_data), 64'(32'hA5A5A5A5));
    drain();

    // Out-of-range read (40,0).
    rd_pend[2] = 1; rd_xv[2] = 40; rd_yv[2] = 0;
    run_cycle();
    check_val("oob_gnt", 64'(obs_rd_gnt), 64'(3'b100));
    check_val("oob_en_a", 64'(obs_en_a), 64'(0));
    run_cycle();
    check_val("oob_pulse", 64'(obs_oob), 64'(1));
    run_cycle();
    check_val("oob_valid", 64'(obs_rd_valid), 64'(3'b100));
    check_val("oob_data", 64'(obs_rd_data), 64'(0));
    drain();

    // Enable dropped after a read: the read still returns, and no new grants are given.
    rd_pend[0] = 1; rd_xv[0] = 1; rd_yv[0] = 1;
    run_cycle();
    enable = 0;
    for (int i = 0; i < N; i++) begin rd_pend[i] = 1; rd_xv[i] = 2; rd_yv[i] = i; end
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      check_val("en_off_gnt", 64'(obs_rd_gnt), 64'(0));
      if (k == 1) check_val("en_off_return", 64'(obs_rd_valid), 64'(3'b001));
    end
    drain();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      gen_requests();
      run_cycle();
    end
    drain();

    // Reset while a read is in flight: the read is lost and no rd_valid appears.
    rd_pend[0] = 1; rd_xv[0] = 2; rd_yv[0] = 2;
    run_cycle();
    rst_n = 0;
    model_reset();
    for (int k = 0; k < 3; k++) reset_cycle();
    rst_n = 1;

    for (int k = 0; k < 80; k++) begin
      gen_requests();
      run_cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
